alt_sng_checker: RTL

- Receive-side checker for the alternating stop-and-go (alt-SNG) keystream.
- Regenerates the expected keystream locally from the same seeds and taps, using clock enables rather than gated clocks.
- Compares it bit-for-bit with a received stream, acquires lock, counts bit errors, and flags a sustained error burst as loss of sync.
- Sits at the far end of a link driven by the alt-SNG generator, for BER and link bring-up.

---
 rtl/alt_sng_pkg.sv | 20 ++
 rtl/sng_lfsr_en.sv | 41 ++++
 rtl/alt_sng_checker.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alt_sng_pkg.sv
// rtl/alt_sng_pkg.sv - shared alt-SNG state encoding and default taps/seeds
package alt_sng_pkg;

  // Checker acquisition / tracking states
  typedef enum logic [1:0] {
    CHECK  = 2'd0,
    LOCKED = 2'd1,
    FAIL   = 2'd2
  } state_t;

  // Defaults shared with the alt-SNG generator so both link ends agree
  localparam int          SNG_WIDTH = 32;
  localparam logic [31:0] SNG_TAPS1 = 32'h80200003;
  localparam logic [31:0] SNG_TAPS2 = 32'hA3000000;
  localparam logic [31:0] SNG_TAPS3 = 32'hD0000001;
  localparam logic [31:0] SNG_SEED1 = 32'h00000001;
  localparam logic [31:0] SNG_SEED2 = 32'h0000ACE1;
  localparam logic [31:0] SNG_SEED3 = 32'h0000BEEF;

endpackage

// File: rtl/sng_lfsr_en.sv
// rtl/sng_lfsr_en.sv - clock-enabled Fibonacci LFSR with synchronous reseed
module sng_lfsr_en #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = 32'h80200003,
  parameter logic [WIDTH-1:0] SEED  = 32'h00000001
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic o
);

  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_d;

  // Reseed has priority over a step; otherwise hold unless enabled
  always_comb begin
    s_d = s_q;
    if (load) begin
      s_d = SEED;
    end else if (en) begin
      s_d = {^(s_q & TAPS), s_q[WIDTH-1:1]};
    end
  end

  // State register, active-low synchronous reset to the seed
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q <= SEED;
    end else begin
      s_q <= s_d;
    end
  end

  assign o = s_q[0];

  // A zero seed would pin the register at zero forever
  a_seed_nonzero: assert property (@(posedge clk) SEED != '0);

endmodule

// File: rtl/alt_sng_checker.sv
// rtl/alt_sng_checker.sv - alt-SNG keystream checker with lock, BER counters and sync-loss detect
module alt_sng_checker
  import alt_sng_pkg::*;
#(
  parameter int               WIDTH      = SNG_WIDTH,
  parameter logic [WIDTH-1:0] TAPS1      = SNG_TAPS1,
  parameter logic [WIDTH-1:0] TAPS2      = SNG_TAPS2,
  parameter logic [WIDTH-1:0] TAPS3      = SNG_TAPS3,
  parameter logic [WIDTH-1:0] SEED1      = SNG_SEED1,
  parameter logic [WIDTH-1:0] SEED2      = SNG_SEED2,
  parameter logic [WIDTH-1:0] SEED3      = SNG_SEED3,
  parameter int               LOCK_CNT   = 16,
  parameter int               WINDOW     = 64,
  parameter int               ERR_THRESH = 4,
  parameter int               CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             resync,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             locked,
  output logic             fail,
  output logic             err_pulse,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);

  logic o1, o2, o3;
  logic step, exp_bit, mismatch;

  // A bit arriving together with resync is dropped entirely
  assign step     = in_valid & ~resync;
  assign exp_bit  = o2 ^ o3;
  assign mismatch = step & (in_bit ^ exp_bit);

  sng_lfsr_en #(.WIDTH(WIDTH), .TAPS(TAPS1), .SEED(SEED1)) u_lfsr1 (
    .clk(clk), .rst(rst), .load(resync), .en(step), .o(o1)
  );
  sng_lfsr_en #(.WIDTH(WIDTH), .TAPS(TAPS2), .SEED(SEED2)) u_lfsr2 (
    .clk(clk), .rst(rst), .load(resync), .en(step & o1), .o(o2)
  );
  sng_lfsr_en #(.WIDTH(WIDTH), .TAPS(TAPS3), .SEED(SEED3)) u_lfsr3 (
    .clk(clk), .rst(rst), .load(resync), .en(step & ~o1), .o(o3)
  );

  state_t           state_q, state_d;
  logic [MW-1:0]    match_cnt_q, match_cnt_d;
  logic [WW-1:0]    win_cnt_q, win_cnt_d, win_cnt_n;
  logic [EW-1:0]    win_err_q, win_err_d, win_err_n;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;

  // Next-state: acquisition, windowed error monitoring and saturating stats
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = mismatch;
    win_cnt_n   = win_cnt_q + WW'(1);
    win_err_n   = win_err_q + EW'(mismatch);

    if (resync) begin
      state_d     = CHECK;
      match_cnt_d = '0;
      win_cnt_d   = '0;
      win_err_d   = '0;
      bit_cnt_d   = '0;
      err_cnt_d   = '0;
      err_pulse_d = 1'b0;
    end else if (step) begin
      case (state_q)
        CHECK: begin
          if (mismatch) begin
            match_cnt_d = '0;
          end else if (match_cnt_q == MW'(LOCK_CNT - 1)) begin
            match_cnt_d = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
            state_d     = LOCKED;
          end else begin
            match_cnt_d = match_cnt_q + MW'(1);
          end
        end
        LOCKED: begin
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (mismatch && err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          if (win_err_n == EW'(ERR_THRESH)) begin
            state_d = FAIL;
          end else if (win_cnt_n == WW'(WINDOW)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_n;
            win_err_d = win_err_n;
          end
        end
        default: begin
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
    fail_d   = (state_d == FAIL);
  end

  // FSM and counter registers with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= CHECK;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
    end
  end

  assign locked    = locked_q;
  assign fail      = fail_q;
  assign err_pulse = err_pulse_q;
  assign bit_cnt   = bit_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
